// File: rtl/csa_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : csa_accumulator_if
//  Purpose  : Operand-stream and result handshake bundle for csa_accumulator.
//             The master drives operands in and consumes the result; the slave
//             is the accumulator itself.
//  Signals  : in_valid/in_ready/in_data/in_last   operand stream
//             out_valid/out_ready/out_sum/out_count/out_ovf   result
//             out_parity   present only with CSA_ACCUMULATOR_PARITY_EN
//  Revision : 1.0  initial release
// ============================================================================
interface csa_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;
`ifdef CSA_ACCUMULATOR_PARITY_EN
    logic                 out_parity;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf, out_parity
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf, out_parity
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
`endif
endinterface
`default_nettype wire

// File: rtl/csa_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : csa_accumulator
//  Purpose  : Multi-operand unsigned accumulator. Operands are folded into a
//             carry-save pair (S, C) one per accepted beat; after in_last the
//             pair is resolved by repeated half-add until C is zero, and the
//             binary sum is presented on a valid/ready output.
//  Ports    : clk     rising-edge clock
//             rst_n   asynchronous active-low reset
//             bus     csa_accumulator_if.slave (operand stream + result)
//  Options  : CSA_ACCUMULATOR_PARITY_EN adds bus.out_parity = ^out_sum,
//             registered together with out_sum.
//  Revision : 1.0  initial release
// ============================================================================
module csa_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_accumulator_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    state_t               state_q;
    logic [ACC_WIDTH-1:0] s_q;
    logic [ACC_WIDTH-1:0] c_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;
    logic [ACC_WIDTH-1:0] out_sum_q;
    logic [CNT_WIDTH-1:0] out_count_q;
    logic                 out_ovf_q;
`ifdef CSA_ACCUMULATOR_PARITY_EN
    logic                 out_parity_q;
`endif

    // Next-state candidates for the two datapath phases.
    logic [ACC_WIDTH-1:0] x_w;
    logic [ACC_WIDTH-1:0] maj_w;
    logic [ACC_WIDTH-1:0] acc_s_d;
    logic [ACC_WIDTH-1:0] acc_c_d;
    logic                 acc_ovf_d;
    logic [ACC_WIDTH-1:0] res_s_d;
    logic [ACC_WIDTH-1:0] res_c_d;
    logic                 res_ovf_d;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        x_w              = '0;
        x_w[WIDTH-1:0]   = bus.in_data;
        // Full-adder array: XOR sum, majority carry shifted one place up.
        maj_w            = (s_q & c_q) | (s_q & x_w) | (c_q & x_w);
        acc_s_d          = s_q ^ c_q ^ x_w;
        acc_c_d          = maj_w << 1;
        // Carry shifted off the top is lost weight 2^ACC_WIDTH.
        acc_ovf_d        = ovf_q | maj_w[ACC_WIDTH-1];
        // Half-adder resolve step.
        res_s_d          = s_q ^ c_q;
        res_c_d          = (s_q & c_q) << 1;
        res_ovf_d        = ovf_q | (s_q[ACC_WIDTH-1] & c_q[ACC_WIDTH-1]);
        cnt_d            = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACCUM;
            s_q          <= '0;
            c_q          <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            out_sum_q    <= '0;
            out_count_q  <= '0;
            out_ovf_q    <= 1'b0;
`ifdef CSA_ACCUMULATOR_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (bus.in_valid) begin
                        s_q   <= acc_s_d;
                        c_q   <= acc_c_d;
                        ovf_q <= acc_ovf_d;
                        cnt_q <= cnt_d;
                        if (bus.in_last) begin
                            state_q <= ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    if (c_q == '0) begin
                        out_sum_q    <= s_q;
                        out_count_q  <= cnt_q;
                        out_ovf_q    <= ovf_q;
`ifdef CSA_ACCUMULATOR_PARITY_EN
                        out_parity_q <= ^s_q;
`endif
                        state_q      <= ST_OUT;
                    end else begin
                        s_q   <= res_s_d;
                        c_q   <= res_c_d;
                        ovf_q <= res_ovf_d;
                    end
                end
                ST_OUT: begin
                    // Result registers are left untouched so they hold both
                    // under backpressure and after the handshake.
                    if (bus.out_ready) begin
                        s_q     <= '0;
                        c_q     <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ST_ACCUM;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    // Handshake flags are pure state decodes.
    assign bus.in_ready   = (state_q == ST_ACCUM);
    assign bus.out_valid  = (state_q == ST_OUT);
    assign bus.out_sum    = out_sum_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_ovf    = out_ovf_q;
`ifdef CSA_ACCUMULATOR_PARITY_EN
    assign bus.out_parity = out_parity_q;
`endif

endmodule
`default_nettype wire

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Parametrised multi-operand accumulator built from a carry-save full-adder array: per-bit XOR sum and majority carry.
- Successor to the single fixed full-adder cell: generalised width, streaming operand input, and an iterative carry-resolve phase.
- Accepts a stream of unsigned operands terminated by `in_last`, then resolves the carry-save pair into a binary sum.
- Presents the sum with operand count and overflow flag on a valid/ready output.

Parameters:
- WIDTH, 8, operand width in bits.
- ACC_WIDTH, 16, accumulator and result width; must be >= WIDTH.
- CNT_WIDTH, 8, operand-count width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  unsigned operand; zero-extended to ACC_WIDTH.
- in_last  input  1  marks final operand of the group; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_WIDTH  resolved sum, modulo 2^ACC_WIDTH.
- out_count  output  CNT_WIDTH  operands accepted, saturating.
- out_ovf  output  1  sticky: a carry was lost off the MSB at any step.

Behaviour:
- Internal state: S and C vectors (ACC_WIDTH each), cnt, ovf, and an FSM {ACCUM, RESOLVE, OUT}.
- Reset values (asynchronous, on rst_n low):
  - state=ACCUM; S=C=0; cnt=0; ovf=0.
  - in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- in_ready = (state==ACCUM). out_valid = (state==OUT). Both are pure state decodes; neither depends combinationally on in_valid or out_ready.
- ACCUM, on in_valid & in_ready, with x = zero-extended in_data:
  - S <= S^C^x.
  - C <= maj(S,C,x)<<1.
  - ovf |= maj bit at MSB.
  - cnt <= min(cnt+1, 2^CNT_WIDTH-1).
  - If in_last, state <= RESOLVE; otherwise stay in ACCUM.
- RESOLVE, every cycle:
  - If C==0: out_sum <= S, out_count <= cnt, out_ovf <= ovf, state <= OUT.
  - Otherwise: S <= S^C, C <= (S&C)<<1, ovf |= S[MSB]&C[MSB].
  - Terminates within ACC_WIDTH+1 cycles.
- OUT:
  - out_sum, out_count and out_ovf are held stable while out_valid & !out_ready.
  - On out_ready: S, C, cnt and ovf are cleared, state <= ACCUM. in_ready rises the following cycle, not in the handshake cycle.
  - out_sum, out_count and out_ovf keep their last values after the handshake; they are meaningful only while out_valid=1.
- Latency, with accept edge t:
  - Single operand: C=0 at entry, so out_valid is high in the cycle after edge t+1.
  - In general: out_valid rises after edge t+1+k, where k = number of half-add iterations.
- Boundary conditions:
  - in_valid while in RESOLVE or OUT: ignored; upstream must hold its data.
  - in_last on the first operand is legal (one-operand group).
  - Count saturates at all-ones; the sum keeps accumulating.
  - Zero operand values are counted.
  - rst_n asserted mid-ACCUM, RESOLVE or OUT: the group is discarded, all outputs go to reset values immediately, and ACCUM resumes after deassertion.

Optional Feature:
- Macro: CSA_ACCUMULATOR_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR-reduce of out_sum.
  - out_parity is registered alongside out_sum in RESOLVE→OUT, resets to 0, and is held stable in OUT.
- Undefined:
  - Port and logic are absent; all other behaviour is identical.

Test Plan:
- Single operand, defaults: in_data=0x05, in_last=1 -> out_sum=0x0005, out_count=1, out_ovf=0; out_valid high 2 cycles after the accept edge.
- Three operands 0xFF, 0xFF, 0x01 (last on third) -> out_sum=0x01FF, out_count=3, out_ovf=0; in_ready=0 from the cycle after last until the cycle after the output handshake.
- Overflow, WIDTH=8, ACC_WIDTH=8: operands 0x80, 0x80 (last) -> out_sum=0x00, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid=1 and out_sum/out_count/out_ovf unchanged every cycle; in_valid pulses ignored; next group of 0x03 gives out_sum=0x0003, out_count=1.
- Count saturation, CNT_WIDTH=2: five operands of 0x01 -> out_count=3, out_sum=0x0005.
- Reset mid-RESOLVE: pulse rst_n low after operands 0x7F, 0x01 (last) -> out_valid=0, outputs zero, in_ready=1 while in reset; a subsequent single 0x02 gives out_sum=0x0002, out_count=1. With CSA_ACCUMULATOR_PARITY_EN defined, 0x0007 -> out_parity=1.
